// File: rtl/sipo_frame_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for a shift-right SIPO: detects a start bit, enables WIDTH shifts,
// then captures the parallel word into a valid/ready holding register with overrun and frame count.
module sipo_frame_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inp,
   input  logic [WIDTH-1:0] sipo_out,
   output logic             sipo_enb,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   input  logic             ready_in,
   input  logic             abort,
   input  logic             clr_ovr,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] frm_cnt
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

   state_t           state_q;
   logic [BW-1:0]    bit_cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             ovr_q;
   logic [CNT_W-1:0] cnt_q;

   logic consume;
   logic load;
   logic drop;

   // A pending word consumed on the capture edge frees the slot for the new word.
   always_comb begin
      consume = valid_q && ready_in;
      load    = (state_q == CAPTURE) && !abort && (!valid_q || ready_in);
      drop    = (state_q == CAPTURE) && !abort && valid_q && !ready_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               bit_cnt_q <= '0;
               if (inp) state_q <= SHIFT;
            end
            SHIFT: begin
               if (abort) begin
                  state_q   <= IDLE;
                  bit_cnt_q <= '0;
               end else if (bit_cnt_q == LAST_BIT) begin
                  state_q   <= CAPTURE;
                  bit_cnt_q <= '0;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               bit_cnt_q <= '0;
            end
         endcase

         if (load) begin
            data_q  <= sipo_out;
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
         end else if (consume) begin
            valid_q <= 1'b0;
         end

         // Set has priority over clear.
         if (drop)
            ovr_q <= 1'b1;
         else if (clr_ovr)
            ovr_q <= 1'b0;
      end
   end

   assign sipo_enb  = (state_q == SHIFT);
   assign busy      = (state_q != IDLE);
   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign overrun   = ovr_q;
   assign frm_cnt   = cnt_q;

endmodule
